cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. It is the clocked successor to the team's 4-bit combinational `cla`. It splits a WIDTH-bit operation into WIDTH/GROUP lookahead groups and resolves one group per pipeline stage, so throughput is one operation per cycle at any width. It sits between operand sources (register file, DSP datapaths) and result consumers that may back-pressure.

## Interface
- `WIDTH`, 16: operand and sum width. Must be a multiple of GROUP; elaboration error otherwise.
- `GROUP`, 4: bits per carry-lookahead group, which is also the number of bits resolved per stage. STAGES = WIDTH/GROUP.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  operands and mode are valid this cycle.
- `in_ready`  output  1  block accepts operands this cycle.
- `A`  input  WIDTH  operand A.
- `B`  input  WIDTH  operand B.
- `Cin`  input  1  carry in. Ignored when `Sub`=1.
- `Sub`  input  1  0: A+B+Cin. 1: A−B, computed as A+~B+1.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `Sum`  output  WIDTH  result, modulo 2^WIDTH.
- `Cout`  output  1  carry out of the MSB. For subtraction, 1 means no borrow.
- `Ovf`  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Internal enable: `en = !out_valid || out_ready`. `in_ready = en`, driven combinationally.
- Acceptance: a transfer occurs when `in_valid && in_ready`. Output handoff occurs when `out_valid && out_ready`.
- When `en`=1, every stage shifts forward by one, including bubbles (valid=0). When `en`=0, all stage registers hold.
- Stage 0 captures A, B' and carry c0:
  - `Sub`=0: B' = B, c0 = Cin.
  - `Sub`=1: B' = ~B, c0 = 1.
- Stage k (0 ≤ k < STAGES) resolves group k, bits [k·GROUP +: GROUP]:
  - Per-bit generate g = a&b, propagate p = a^b.
  - Lookahead carries: c[i+1] = g[i] | p[i]&c[i], flattened within the group (no ripple).
  - Sum bits = p ^ c.
  - Group carry-out is registered into stage k+1.
- Skew handling: already-resolved lower sum bits and not-yet-resolved upper operand bits travel with each entry. No operand is read after acceptance.
- Last stage: registers full `Sum`, `Cout` (group carry-out) and `Ovf` (carry into MSB XOR `Cout`).
- Results leave in acceptance order. No reordering, no drops, no duplicates.
- A bubble never produces `out_valid`=1.

## Timing
- Latency: operands accepted at rising edge t give `out_valid`=1 with the matching result after edge t+STAGES−1+1, i.e. visible from cycle t+STAGES (4 cycles for defaults).
- Throughput: one operation per cycle while `out_ready`=1.
- Back-pressure:
  - `out_valid`=1 with `out_ready`=0 drops `in_ready` to 0 in the same cycle.
  - `Sum`, `Cout` and `Ovf` stay stable while `out_valid`=1 and `out_ready`=0.
- Empty pipe with `out_ready`=0: `in_ready`=1, because bubbles may advance.
- Simultaneous output handoff and input acceptance in the same cycle is legal and required for full throughput.
- Reset:
  - Every stage valid bit clears.
  - `out_valid`=0, `Sum`=0, `Cout`=0, `Ovf`=0.
  - `in_ready`=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight entries. No result from before reset may appear afterwards.
  - `rst` has priority over `en`.
- Combinational paths: `out_ready`→`in_ready` only. No path from `A`, `B`, `Cin` or `Sub` to any output.

## Test plan
- Add with wrap, WIDTH=16: A=0x0001, B=0xFFFF, Cin=0, Sub=0 → Sum=0x0000, Cout=1, Ovf=0, `out_valid` exactly 4 cycles after acceptance.
- Subtract with borrow: A=0x0005, B=0x0007, Sub=1 → Sum=0xFFFE, Cout=0, Ovf=0. Signed overflow: A=0x7FFF, B=0x0001, Sub=0 → Sum=0x8000, Cout=0, Ovf=1.
- Full carry chain across all groups: A=0xFFFF, B=0x0000, Cin=1 → Sum=0x0000, Cout=1. Repeat with GROUP=2, 8 and 16 (latency 8, 2, 1).
- Stream and back-pressure:
  - Issue 6 back-to-back ops, hold `out_ready`=0 for 3 cycles mid-stream.
  - Required: `in_ready`=0 during the stall, outputs held stable, all 6 results in order, none lost.
- Reset mid-flight: accept 3 ops, assert `rst` for 1 cycle → `out_valid` stays 0 until a new op is accepted. The new op's result arrives after STAGES cycles.
- Random regression: 10 000 random A, B, Cin, Sub with random `in_valid`/`out_ready` → every result matches a behavioural A±B model, including Cout and Ovf.

Source files
------------

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_adder
// Description : Pipelined carry-lookahead adder/subtractor, one GROUP-bit
//               lookahead group resolved per stage, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int STAGES = WIDTH / GROUP;

    generate
        if ((WIDTH % GROUP) != 0) begin : g_width_check
            $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
        end
    endgenerate

    // Per-stage entry: x_q carries resolved sum bits below the current group
    // and untouched A bits from the current group upward.
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  x_q     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [STAGES-1:0] carry_q;

    logic [WIDTH-1:0]  x_d     [STAGES];
    logic [STAGES-1:0] carry_d;
    logic              cmsb_d;

    logic              out_valid_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic              en;

    // Two-level sum-of-products carries: each c[i+1] is formed directly from
    // g/p terms and c0, so no carry ripples through earlier bits of the group.
    function automatic logic [GROUP:0] lookahead(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           prod;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            prod = c0;
            for (int m = 0; m <= i; m++) begin
                prod = prod & p[m];
            end
            c[i+1] = prod;
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    prod = prod & p[m];
                end
                c[i+1] = c[i+1] | prod;
            end
        end
        return c;
    endfunction

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        logic [GROUP-1:0] g_w;
        logic [GROUP-1:0] p_w;
        logic [GROUP:0]   c_w;
        g_w     = '0;
        p_w     = '0;
        c_w     = '0;
        carry_d = '0;
        cmsb_d  = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            g_w = x_q[k][k*GROUP +: GROUP] & b_q[k][k*GROUP +: GROUP];
            p_w = x_q[k][k*GROUP +: GROUP] ^ b_q[k][k*GROUP +: GROUP];
            c_w = lookahead(g_w, p_w, carry_q[k]);
            x_d[k] = x_q[k];
            x_d[k][k*GROUP +: GROUP] = p_w ^ c_w[GROUP-1:0];
            carry_d[k] = c_w[GROUP];
            if (k == STAGES - 1) begin
                cmsb_d = c_w[GROUP-1];
            end
        end
    end

    // Control and output registers; reset wins over the shift enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            out_valid_q <= valid_q[STAGES-1];
            sum_q       <= x_d[STAGES-1];
            cout_q      <= carry_d[STAGES-1];
            ovf_q       <= cmsb_d ^ carry_d[STAGES-1];
        end
    end

    // Operand/skew datapath needs no reset: its contents only matter with valid.
    always_ff @(posedge clk) begin
        if (en) begin
            x_q[0]     <= A;
            b_q[0]     <= Sub ? ~B : B;
            carry_q[0] <= Sub | Cin;
            for (int k = 1; k < STAGES; k++) begin
                x_q[k]     <= x_d[k-1];
                b_q[k]     <= b_q[k-1];
                carry_q[k] <= carry_d[k-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe_adder
// Description : Directed and random self-checking bench for cla_pipe_adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Cin = 1'b0;
    logic        Sub = 1'b0;

    logic        in_ready, out_valid, Cout, Ovf;
    logic [15:0] Sum;
    logic        in_ready2, out_valid2, Cout2, Ovf2;
    logic [15:0] Sum2;
    logic        in_ready8, out_valid8, Cout8, Ovf8;
    logic [15:0] Sum8;
    logic        in_ready16, out_valid16, Cout16, Ovf16;
    logic [15:0] Sum16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid),
        .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .Ovf(Ovf));

    cla_pipe_adder #(.WIDTH(16), .GROUP(2)) dut_g2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid2),
        .out_ready(out_ready), .Sum(Sum2), .Cout(Cout2), .Ovf(Ovf2));

    cla_pipe_adder #(.WIDTH(16), .GROUP(8)) dut_g8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid8),
        .out_ready(out_ready), .Sum(Sum8), .Cout(Cout8), .Ovf(Ovf8));

    cla_pipe_adder #(.WIDTH(16), .GROUP(16)) dut_g16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid16),
        .out_ready(out_ready), .Sum(Sum16), .Cout(Cout16), .Ovf(Ovf16));

    // Stream vectors: {a, b, cin, sub} and expected {sum, cout, ovf}.
    logic [15:0] st_a   [6] = '{16'h1234, 16'h8000, 16'h0010, 16'h00FF, 16'h8000, 16'hFFFF};
    logic [15:0] st_b   [6] = '{16'h1111, 16'h8000, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
    logic        st_cin [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        st_sub [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [17:0] st_exp [6] = '{{16'h2345, 2'b00}, {16'h0000, 2'b11}, {16'h000F, 2'b10},
                                {16'h0101, 2'b00}, {16'h7FFF, 2'b11}, {16'hFFFF, 2'b10}};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Drives one op into an empty pipe, returns cycles until out_valid (-1 on timeout).
    task automatic issue_and_wait(input logic [15:0] a, input logic [15:0] b,
                                  input logic ci, input logic su, output int lat);
        A = a; B = b; Cin = ci; Sub = su;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic su);
        logic [16:0] full;
        logic [15:0] bp;
        logic        ovf;
        bp   = su ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {16'd0, (su ? 1'b1 : ci)};
        ovf  = (a[15] == bp[15]) && (full[15] != a[15]);
        return {full[15:0], full[16], ovf};
    endfunction

    task automatic test_reset();
        apply_reset();
        out_ready = 1'b0;
        #1;
        checks++;
        if ({out_valid, Sum, Cout, Ovf} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, want all zero",
                     out_valid, Sum, Cout, Ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready_empty_stall: got %b, want 1", in_ready);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_add_wrap();
        int lat;
        issue_and_wait(16'h0001, 16'hFFFF, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL add_wrap_latency: got %0d, want 4", lat);
        end
        checks++;
        if ({Sum, Cout, Ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_wrap: got sum=%h cout=%b ovf=%b, want 0000 1 0", Sum, Cout, Ovf);
        end
    endtask

    task automatic test_sub_borrow();
        int lat;
        // Cin=1 must be ignored in subtract mode
        issue_and_wait(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
        checks++;
        if (lat != 4 || {Sum, Cout, Ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got lat=%0d sum=%h cout=%b ovf=%b, want 4 FFFE 0 0",
                     lat, Sum, Cout, Ovf);
        end
    endtask

    task automatic test_signed_ovf();
        int lat;
        issue_and_wait(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 4 || {Sum, Cout, Ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL signed_ovf: got lat=%0d sum=%h cout=%b ovf=%b, want 4 8000 0 1",
                     lat, Sum, Cout, Ovf);
        end
    endtask

    task automatic test_group_variants();
        int l4 = -1, l2 = -1, l8 = -1, l16 = -1;
        logic [17:0] r4 = '0, r2 = '0, r8 = '0, r16 = '0;
        apply_reset();
        out_ready = 1'b1;
        checks++;
        if ({in_ready, in_ready2, in_ready8, in_ready16} !== 4'b1111) begin
            errors++;
            $display("FAIL group_in_ready: got %b, want 1111",
                     {in_ready, in_ready2, in_ready8, in_ready16});
        end
        A = 16'hFFFF; B = 16'h0000; Cin = 1'b1; Sub = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (out_valid   && l4  < 0) begin l4  = n; r4  = {Sum,   Cout,   Ovf};   end
            if (out_valid2  && l2  < 0) begin l2  = n; r2  = {Sum2,  Cout2,  Ovf2};  end
            if (out_valid8  && l8  < 0) begin l8  = n; r8  = {Sum8,  Cout8,  Ovf8};  end
            if (out_valid16 && l16 < 0) begin l16 = n; r16 = {Sum16, Cout16, Ovf16}; end
        end
        checks++;
        if (l4 != 4 || r4 !== {16'h0000, 2'b10}) begin
            errors++;
            $display("FAIL carry_chain_g4: got lat=%0d res=%h, want 4 %h", l4, r4, {16'h0000, 2'b10});
        end
        checks++;
        if (l2 != 8 || r2 !== {16'h0000, 2'b10}) begin
            errors++;
            $display("FAIL carry_chain_g2: got lat=%0d res=%h, want 8 %h", l2, r2, {16'h0000, 2'b10});
        end
        checks++;
        if (l8 != 2 || r8 !== {16'h0000, 2'b10}) begin
            errors++;
            $display("FAIL carry_chain_g8: got lat=%0d res=%h, want 2 %h", l8, r8, {16'h0000, 2'b10});
        end
        checks++;
        if (l16 != 1 || r16 !== {16'h0000, 2'b10}) begin
            errors++;
            $display("FAIL carry_chain_g16: got lat=%0d res=%h, want 1 %h", l16, r16, {16'h0000, 2'b10});
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        logic [17:0] held = '0;
        logic have_held = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid = (sent < 6);
            if (sent < 6) begin
                A = st_a[sent]; B = st_b[sent]; Cin = st_cin[sent]; Sub = st_sub[sent];
            end
            #1;
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: cycle %0d got %b, want 0", cyc, in_ready);
                end
                if (have_held) begin
                    checks++;
                    if ({Sum, Cout, Ovf} !== held) begin
                        errors++;
                        $display("FAIL stall_hold: cycle %0d got %h, want %h", cyc, {Sum, Cout, Ovf}, held);
                    end
                end else begin
                    held = {Sum, Cout, Ovf};
                    have_held = 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({Sum, Cout, Ovf} !== st_exp[got]) begin
                    errors++;
                    $display("FAIL stream_result[%0d]: got %h, want %h", got, {Sum, Cout, Ovf}, st_exp[got]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 6 || !have_held) begin
            errors++;
            $display("FAIL stream_count: got %0d results (stall seen=%b), want 6 (1)", got, have_held);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        int stray = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = 16'h0100 + 16'(i); B = 16'h0001; Cin = 1'b0; Sub = 1'b0;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (out_valid) stray++;
            step();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_flush: got %0d stray valid cycles, want 0", stray);
        end
        issue_and_wait(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 4 || {Sum, Cout, Ovf} !== {16'h0007, 2'b00}) begin
            errors++;
            $display("FAIL post_reset_op: got lat=%0d sum=%h cout=%b ovf=%b, want 4 0007 0 0",
                     lat, Sum, Cout, Ovf);
        end
    endtask

    task automatic test_random();
        logic [17:0] exp_q [$];
        logic [17:0] e;
        int accepted = 0;
        apply_reset();
        for (int cyc = 0; cyc < 60000 && accepted < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A = 16'($urandom); B = 16'($urandom);
            Cin = 1'($urandom); Sub = 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra: got %h with nothing outstanding", {Sum, Cout, Ovf});
                end else begin
                    e = exp_q.pop_front();
                    if ({Sum, Cout, Ovf} !== e) begin
                        errors++;
                        $display("FAIL random_result: got %h, want %h", {Sum, Cout, Ovf}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(A, B, Cin, Sub));
                accepted++;
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_drain_extra: got %h", {Sum, Cout, Ovf});
                end else begin
                    e = exp_q.pop_front();
                    if ({Sum, Cout, Ovf} !== e) begin
                        errors++;
                        $display("FAIL random_drain: got %h, want %h", {Sum, Cout, Ovf}, e);
                    end
                end
            end
            step();
        end
        checks++;
        if (accepted != 10000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_complete: accepted %0d, outstanding %0d, want 10000 and 0",
                     accepted, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_borrow();
        test_signed_ovf();
        test_group_variants();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
